// File: rtl/mcycle_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mcycle_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Iteration counter width for a given operand width (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mcycle_datapath.sv
// Shift-add multiply / restoring divide datapath, one bit per step.
// acc holds {high, low}: multiply {partial product, multiplier}, divide {remainder, dividend/quotient}.
module mcycle_datapath
    import mcycle_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               op,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic [2*WIDTH-1:0] acc_next
);

    logic               op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (op_q == OP_MUL)
            acc_next = {sum, acc[WIDTH-1:1]};
        else if (!trial[WIDTH])
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end

    // opnd_q is the multiplicand or the divisor; the other operand seeds acc's low half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_MUL;
            opnd_q <= '0;
            acc    <= '0;
        end else if (load) begin
            op_q   <= op;
            opnd_q <= (op == OP_DIV) ? operand2 : operand1;
            acc    <= {{WIDTH{1'b0}}, (op == OP_DIV) ? operand1 : operand2};
        end else if (step) begin
            acc    <= acc_next;
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit: Start/MCycleOp in, Busy while iterating, one-cycle done pulse.
module mcycle_unit
    import mcycle_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] acc_next;

    assign load = Start && (state == IDLE || state == DONE);
    assign step = (state == COMPUTE);

    mcycle_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (CLK),
        .rst      (RESET),
        .load     (load),
        .step     (step),
        .op       (MCycleOp),
        .operand1 (Operand1),
        .operand2 (Operand2),
        .acc_next (acc_next)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            Busy    <= 1'b0;
            done    <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (Start) begin
                        state <= COMPUTE;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        Result1 <= acc_next[WIDTH-1:0];
                        Result2 <= acc_next[2*WIDTH-1:WIDTH];
                        state   <= DONE;
                        Busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // A Start seen while done is high chains straight into the next operation.
                    if (Start) begin
                        state <= COMPUTE;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed plus randomized checks of mcycle_unit against an arithmetic reference model.
module tb_mcycle_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         Start = 1'b0;
    logic         MCycleOp = 1'b0;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact unsigned arithmetic; divide by zero gives all ones / dividend.
    function automatic logic [63:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        if (op == 1'b0) begin
            p = longint'(a) * longint'(b);
            return p;
        end
        if (b == 0) return {a, {W{1'b1}}};
        return {a % b, a / b};
    endfunction

    // Present a request, clock it in, then confirm the unit went busy immediately.
    task automatic start_op(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        @(posedge CLK); #1;
        Start = 1'b0;
        check({tag, "_busy0"}, {63'd0, Busy}, 64'd1);
        check({tag, "_done0"}, {63'd0, done}, 64'd0);
    endtask

    // Watch cycles after the accepting edge until done; optionally fire a conflicting Start mid-compute.
    task automatic observe(input string tag, input logic [63:0] exp, input bit inject);
        int busy_cnt = 1;
        int done_at = -1;
        int both = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            if (inject && c == 10) begin
                Start = 1'b1; MCycleOp = ~MCycleOp; Operand1 = 32'h0000_FFFF; Operand2 = 32'd3;
            end
            if (inject && c == 11) Start = 1'b0;
            if (Busy && done) both++;
            if (done) begin
                done_at = c;
                break;
            end
            if (Busy) busy_cnt++;
        end
        check({tag, "_done_at"}, 64'(done_at), 64'(W));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, "_overlap"}, 64'(both), 64'd0);
        check({tag, "_result"}, {Result2, Result1}, exp);
    endtask

    task automatic expect_idle(input string tag);
        @(posedge CLK); #1;
        check({tag, "_done_drop"}, {63'd0, done}, 64'd0);
        check({tag, "_busy_drop"}, {63'd0, Busy}, 64'd0);
    endtask

    initial begin
        logic        rop;
        logic [W-1:0] ra, rb;
        int          dcount;

        // Reset state
        #12;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_res", {Result2, Result1}, 64'd0);
        @(negedge CLK); RESET = 1'b0;
        @(posedge CLK); #1;

        // Multiply 3 x 5, then all-ones squared
        start_op("mul3x5", 1'b0, 32'd3, 32'd5);
        observe("mul3x5", 64'h0000_0000_0000_000F, 1'b0);
        expect_idle("mul3x5");
        start_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        observe("mulmax", 64'hFFFF_FFFE_0000_0001, 1'b0);
        expect_idle("mulmax");

        // Divide, divide by zero
        start_op("div100_7", 1'b1, 32'd100, 32'd7);
        observe("div100_7", {32'd2, 32'd14}, 1'b0);
        expect_idle("div100_7");
        start_op("div0", 1'b1, 32'h0000_1234, 32'd0);
        observe("div0", {32'h0000_1234, 32'hFFFF_FFFF}, 1'b0);
        expect_idle("div0");

        // Start during COMPUTE is ignored
        start_op("ignore", 1'b0, 32'd3, 32'd5);
        observe("ignore", 64'h0000_0000_0000_000F, 1'b1);
        expect_idle("ignore");

        // Back-to-back: Start held in the done cycle
        start_op("b2b_a", 1'b1, 32'd100, 32'd7);
        observe("b2b_a", {32'd2, 32'd14}, 1'b0);
        start_op("b2b_b", 1'b1, 32'd9, 32'd2);
        observe("b2b_b", {32'd1, 32'd4}, 1'b0);
        expect_idle("b2b_b");

        // Asynchronous reset mid-multiply
        start_op("arst", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_res", {Result2, Result1}, 64'd0);
        #2 RESET = 1'b0;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (done || Busy) dcount++;
        end
        check("arst_quiet", 64'(dcount), 64'd0);
        start_op("arst_next", 1'b0, 32'd7, 32'd6);
        observe("arst_next", 64'd42, 1'b0);
        expect_idle("arst_next");

        // Randomized operations against the reference model
        for (int n = 0; n < 20; n++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            start_op($sformatf("rnd%0d", n), rop, ra, rb);
            observe($sformatf("rnd%0d", n), model(rop, ra, rb), 1'b0);
            if ($urandom_range(0, 1) == 1) expect_idle($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
